// File: rtl/cpu_step_controller_if.sv
// Datapath-side bundle of the step controller.
// master: controller side. Receives pc, bp_en and bp_addr. Drives cpu_en,
//         halted, state and step_count.
// slave:  datapath/status side, with the opposite directions.
interface cpu_step_controller_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pc;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic            cpu_en;
    logic            halted;
    logic [1:0]      state;
    logic [15:0]     step_count;

    modport master (
        input  pc, bp_en, bp_addr,
        output cpu_en, halted, state, step_count
    );

    modport slave (
        output pc, bp_en, bp_addr,
        input  cpu_en, halted, state, step_count
    );
endinterface

// File: rtl/cpu_step_controller.sv
// Clock-enable sequencer for the single-cycle 8-bit RISC-V datapath.
// It produces one-cycle cpu_en pulses on the board clock in three ways:
// a debounced single step, a divided free-run, and a stop on a PC breakpoint.
// Ports:
//   clk        system clock (CLOCK_50)
//   rst        asynchronous reset, active-low
//   step_key_n raw step push-button, active-low, asynchronous
//   run_sw     run-mode switch, asynchronous; 1 = free-run
//   bus        master modport:
//                inputs  pc, bp_en, bp_addr
//                outputs cpu_en, halted, state, step_count
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | waiting for a press or for run_sw
// STEP   | single pulse cycle (cpu_en=1), then back to IDLE
// RUN    | free-run, one pulse every RUN_DIV cycles
// BREAK  | stopped at breakpoint, halted=1
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 50000000,
    parameter int PC_W            = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_key_n,
    input  logic                  run_sw,
    cpu_step_controller_if.master bus
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_STEP  = 2'b01,
        S_RUN   = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    logic            key_s1, key_s2, key_db;
    logic            run_s1, run_sync;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    state_t           state_q, state_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic             armed_q, armed_n;
    logic             en_q, en_n;
    logic             halted_q;
    logic [15:0]      step_count_q;
    logic             bp_hit;

    // Input conditioning. The synchronized key must differ from the
    // debounced level for DEBOUNCE_CYCLES consecutive cycles before it is
    // accepted. press fires only when the accepted level falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_db   <= 1'b1;
            run_s1   <= 1'b0;
            run_sync <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            key_s1   <= step_key_n;
            key_s2   <= key_s1;
            run_s1   <= run_sw;
            run_sync <= run_s1;
            press    <= 1'b0;
            if (key_s2 != key_db) begin
                if (db_cnt == DB_LAST) begin
                    key_db <= key_s2;
                    db_cnt <= '0;
                    press  <= key_db;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign bp_hit = armed_q && bus.bp_en && (bus.pc == bus.bp_addr);

    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        armed_n = armed_q;
        en_n    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run_sync) begin
                    state_n = S_RUN;
                    div_n   = '0;
                    armed_n = 1'b0;
                end else if (press) begin
                    state_n = S_STEP;
                    en_n    = 1'b1;
                end
            end
            S_STEP: begin
                state_n = S_IDLE;
            end
            S_RUN: begin
                // Arm only once a pulse has actually advanced the PC, so
                // entering RUN while sitting on bp_addr executes that
                // instruction instead of breaking on it again.
                if (en_q) begin
                    armed_n = 1'b1;
                end
                if (!run_sync) begin
                    state_n = S_IDLE;
                    div_n   = '0;
                end else if (bp_hit) begin
                    state_n = S_BREAK;
                    div_n   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_n = '0;
                    en_n  = 1'b1;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (!run_sync) begin
                    state_n = S_IDLE;
                end else if (press) begin
                    state_n = S_STEP;
                    en_n    = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // The pulse and its count are registered together, so step_count
    // already includes the pulse during the cycle in which cpu_en is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            armed_q      <= 1'b0;
            en_q         <= 1'b0;
            halted_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q  <= state_n;
            div_q    <= div_n;
            armed_q  <= armed_n;
            en_q     <= en_n;
            halted_q <= (state_n == S_BREAK);
            if (en_n) begin
                step_count_q <= step_count_q + 16'd1;
            end
        end
    end

    assign bus.cpu_en     = en_q;
    assign bus.halted     = halted_q;
    assign bus.state      = state_q;
    assign bus.step_count = step_count_q;

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Clock-enable sequencer for the single-cycle 8-bit RISC-V datapath: program counter, register file, data memory.
- Replaces the raw push-button datapath clock with one-cycle enable pulses generated on the 50 MHz board clock.
- Modes: debounced single-step, free-run at a divided rate, and halt on a program-counter breakpoint.
- Its outputs drive the datapath enable, status LEDs and the LCD step counter.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized cycles required to accept a key level (20 ms at 50 MHz).
- RUN_DIV, 50000000: clk cycles per enable pulse in RUN (1 Hz at 50 MHz); must be ≥2.
- PC_W, 8: program-counter width.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous reset, active-low
- step_key_n  in  1  raw step push-button, active-low, asynchronous to clk
- run_sw  in  1  run-mode switch, asynchronous to clk; 1 = free-run
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_W  breakpoint address
- pc  in  PC_W  current datapath PC; updates on the clk edge where cpu_en=1
- cpu_en  out  1  datapath clock enable; one-cycle pulse
- halted  out  1  1 while in BREAK
- state  out  2  IDLE=00, STEP=01, RUN=10, BREAK=11
- step_count  out  16  number of cpu_en pulses issued

Behaviour:
- Reset (rst=0, asynchronous) drives:
  - state=IDLE, cpu_en=0, halted=0, step_count=0.
  - Divider=0, debounce counter=0, armed flag=0.
  - step_key_n synchronizer and debounced level to 1 (released); run_sw synchronizer to 0.
- Reset applied mid-pulse or mid-run aborts immediately; no pulse is issued after release until a new trigger occurs.
- Input conditioning:
  - step_key_n and run_sw each pass through a 2-flop synchronizer.
  - Debounced key level changes only after the synchronized key differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - press = one-cycle strobe on the debounced 1→0 transition. Release produces no event.
  - run_sw is level-sensitive after synchronization; it is not debounced.
- All outputs are registered. cpu_en=1 for exactly one cycle per pulse and never on two consecutive cycles.
- IDLE:
  - run_sync=1 → RUN, with divider=0 and armed=0.
  - Else press → STEP.
- STEP:
  - cpu_en=1 during this cycle; next state is IDLE unconditionally.
- RUN:
  - The divider counts 0..RUN_DIV-1 and wraps.
  - At divider=RUN_DIV-1, cpu_en=1 for the following cycle and armed is set.
  - Priority 1: run_sync=0 → IDLE, divider cleared, no pulse.
  - Priority 2: armed=1, bp_en=1 and pc==bp_addr → BREAK, with any pending pulse suppressed.
  - The armed flag prevents an immediate break when RUN is entered with pc already at bp_addr.
  - press is ignored.
- BREAK:
  - halted=1.
  - run_sync=0 → IDLE (priority).
  - Else press → STEP. After STEP the block goes to IDLE and re-enters RUN with armed=0 if run_sw is still 1, so the breakpoint is stepped past.
  - bp_en=0 does not leave BREAK.
- step_count increments on every cpu_en pulse and wraps 0xFFFF→0x0000.
- A press coinciding with the run_sync 0→1 transition in IDLE: RUN wins and the press is discarded.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4 and RUN_DIV=8.
- Reset values: assert rst=0 mid-simulation → state=00, cpu_en=0, halted=0, step_count=0 asynchronously.
- Single step:
  - Hold step_key_n=0 for 10 cycles → exactly one cpu_en pulse, step_count=1, state returns to 00.
  - Release produces no pulse.
- Bounce rejection: toggle step_key_n 0/1 every 2 cycles for 20 cycles, then hold 1 → no cpu_en pulse, step_count=0.
- Free-run:
  - run_sw=1 for 100 cycles with bp_en=0 → cpu_en pulses every 8 cycles, never on adjacent cycles, state=10.
  - run_sw=0 → state=00 within 3 cycles, no further pulses.
- Breakpoint:
  - bp_en=1, bp_addr=0x0C, model pc+=4 per pulse from 0 → BREAK after the third pulse, halted=1, state=11, step_count=3.
  - With run_sw still 1, a press produces 1 pulse, then run resumes past 0x0C.
- Wrap: preload via 65535 single pulses, or use a force → the next pulse gives step_count=0x0000.
